// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   ST_IDLE/ST_RUN/ST_DONE : state encodings used by the sequencing FSM
//   WIDTH_DEF              : default operand width, matching the 6-bit adder family
//   cnt_width()            : bit-counter width for a given operand width (minimum 1)
package serial_adder_ctrl_pkg;

   localparam int WIDTH_DEF = 6;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_e;

   // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice;
   // a 1-bit operand still needs a 1-bit counter to be well formed.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell shared across all bit positions of the
// serial adder. Purely combinational.
//   a, b, cin : addend bits and carry-in
//   so        : sum bit
//   cout      : carry-out
module serial_adder_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic so,
   output logic cout
);

   assign so   = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller. One full-adder cell is time-multiplexed
// over a WIDTH-bit operand pair, LSB first, one bit per clock.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : request, sampled only in IDLE or DONE
//   a, b, cin    : operands and carry-in, captured on the accepting edge
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when sum/cout/ovf become valid
//   sum, cout    : registered result and carry out of the MSB, held
//   ovf          : registered two's-complement overflow, held
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | one bit per edge, counter 0..WIDTH-1
// S_DONE  | result valid, done pulse; start re-enters S_RUN directly
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PENULT = (WIDTH > 1) ? CNT_W'(WIDTH - 2) : '0;

   state_e           state;
   state_e           state_nxt;
   logic             accept;
   logic             step;
   logic             last;
   logic             msb_in;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_sr_nxt;
   logic             carry;
   logic             c_msb;
   logic [CNT_W-1:0] cnt;

   logic             fa_so;
   logic             fa_cout;

   serial_adder_ctrl_fa u_fa (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .so   (fa_so),
      .cout (fa_cout)
   );

   assign last   = (cnt == CNT_LAST);
   // For a 1-bit operand the carry into the MSB is cin itself, loaded at accept.
   assign msb_in = (WIDTH > 1) && (cnt == CNT_PENULT);

   // New sum bit enters at the MSB; after WIDTH steps the LSB has reached bit 0.
   assign sum_sr_nxt = (sum_sr >> 1) | (WIDTH'(fa_so) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         c_msb  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         op_a   <= a;
         op_b   <= b;
         sum_sr <= '0;
         carry  <= cin;
         c_msb  <= cin;
         cnt    <= '0;
      end else if (step) begin
         op_a   <= op_a >> 1;
         op_b   <= op_b >> 1;
         sum_sr <= sum_sr_nxt;
         carry  <= fa_cout;
         if (msb_in) begin
            c_msb <= fa_cout;
         end
         if (last) begin
            // Counter is parked at zero rather than stepping past WIDTH-1.
            cnt  <= '0;
            sum  <= sum_sr_nxt;
            cout <= fa_cout;
            ovf  <= c_msb ^ fa_cout;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

   logic       clk;
   logic       rst;
   logic       start_v [2];
   logic [5:0] a_v     [2];
   logic [5:0] b_v     [2];
   logic       cin_v   [2];

   logic       busy0, done0, cout0, ovf0;
   logic [5:0] sum0;
   logic       busy1, done1, cout1, ovf1;
   logic [0:0] sum1;
   logic [0:0] a1, b1;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   assign a1 = a_v[1][0:0];
   assign b1 = b_v[1][0:0];

   serial_adder_ctrl #(.WIDTH(6)) dut6 (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
      .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a1), .b(b1), .cin(cin_v[1]),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] sum;
      logic       cout;
      logic       ovf;
   } res_t;

   // Arithmetic reference: unsigned sum for sum/cout, signed range test for ovf.
   function automatic res_t ref_add(input int w, input longint av, input longint bv, input logic c);
      res_t   r;
      longint m, half, t, sa, sb, s, aa, bb;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      aa   = av & m;
      bb   = bv & m;
      t    = aa + bb + longint'(c);
      r.sum  = 6'(t & m);
      r.cout = ((t >> w) & 1) != 0;
      sa   = (aa >= half) ? aa - (m + 1) : aa;
      sb   = (bb >= half) ? bb - (m + 1) : bb;
      s    = sa + sb + longint'(c);
      r.ovf  = (s >= half) || (s < -half);
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: cycles remaining in an operation, pending result,
   // and the visible held outputs.
   int         m_left [2];
   bit         m_done [2];
   logic [5:0] m_sum  [2];
   logic       m_cout [2];
   logic       m_ovf  [2];
   res_t       m_pend [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_left[k] = 0;
            m_done[k] = 0;
            m_sum[k]  = '0;
            m_cout[k] = 0;
            m_ovf[k]  = 0;
         end else if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               m_done[k] = 1;
               m_sum[k]  = m_pend[k].sum;
               m_cout[k] = m_pend[k].cout;
               m_ovf[k]  = m_pend[k].ovf;
            end
         end else begin
            m_done[k] = 0;
            if (start_v[k]) begin
               m_pend[k] = ref_add((k == 0) ? 6 : 1, longint'(a_v[k]), longint'(b_v[k]), cin_v[k]);
               m_left[k] = (k == 0) ? 6 : 1;
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      #1 chk_en = 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy6", 32'(busy0), 32'(m_left[0] > 0));
         check("done6", 32'(done0), 32'(m_done[0]));
         check("sum6",  32'(sum0),  32'(m_sum[0]));
         check("cout6", 32'(cout0), 32'(m_cout[0]));
         check("ovf6",  32'(ovf0),  32'(m_ovf[0]));
         check("busy1", 32'(busy1), 32'(m_left[1] > 0));
         check("done1", 32'(done1), 32'(m_done[1]));
         check("sum1",  32'(sum1),  32'(m_sum[1][0]));
         check("cout1", 32'(cout1), 32'(m_cout[1]));
         check("ovf1",  32'(ovf1),  32'(m_ovf[1]));
      end
   end

   function automatic logic busy_of(input int k);
      return (k == 0) ? busy0 : busy1;
   endfunction

   function automatic logic done_of(input int k);
      return (k == 0) ? done0 : done1;
   endfunction

   // Waits for done after a start has been driven. Unless hold is set, start
   // is dropped and operands scrambled every cycle; on cycle 'poke' a stray
   // start with a=1,b=1 is raised instead.
   task automatic run_op(input int k, input int poke, input bit hold, output int cyc, output int nbusy);
      cyc   = 0;
      nbusy = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (busy_of(k)) nbusy++;
         if (!hold) begin
            start_v[k] = (cyc == poke);
            a_v[k]     = (cyc == poke) ? 6'd1 : 6'($urandom);
            b_v[k]     = (cyc == poke) ? 6'd1 : 6'($urandom);
            cin_v[k]   = 1'($urandom);
         end
      end while (!done_of(k) && cyc < 40);
      if (!done_of(k)) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout_dut%0d: got no done, want done within 40 cycles", k);
      end
   endtask

   task automatic launch(input int k, input logic [5:0] av, input logic [5:0] bv, input logic c);
      @(negedge clk);
      start_v[k] = 1;
      a_v[k]     = av;
      b_v[k]     = bv;
      cin_v[k]   = c;
   endtask

   initial begin
      int   cyc, nb, nd;
      res_t r;

      rst = 1;
      for (int k = 0; k < 2; k++) begin
         start_v[k] = 0;
         a_v[k]     = '0;
         b_v[k]     = '0;
         cin_v[k]   = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy0), 0);
      check("rst_done", 32'(done0), 0);
      check("rst_sum",  32'(sum0),  0);
      rst = 0;

      r = ref_add(6, 37, 29, 0);
      check("ref_basic", 32'(r), {24'd0, 6'd2, 1'b1, 1'b0});
      r = ref_add(6, 63, 0, 1);
      check("ref_chain", 32'(r), {24'd0, 6'd0, 1'b1, 1'b0});
      r = ref_add(6, 31, 1, 0);
      check("ref_sovf",  32'(r), {24'd0, 6'd32, 1'b0, 1'b1});
      r = ref_add(1, 1, 1, 1);
      check("ref_w1",    32'(r), {24'd0, 6'd1, 1'b1, 1'b0});

      // Basic add with a stray start mid-RUN and scrambled operands.
      launch(0, 6'd37, 6'd29, 1'b0);
      run_op(0, 3, 0, cyc, nb);
      check("basic_lat",  32'(cyc), 7);
      check("basic_busy", 32'(nb), 6);
      check("basic_sum",  32'(sum0), 2);
      check("basic_cout", 32'(cout0), 1);
      check("basic_ovf",  32'(ovf0), 0);
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         nd += int'(done0);
      end
      check("stray_start_no_done", 32'(nd), 0);

      launch(0, 6'h3F, 6'd0, 1'b1);
      run_op(0, 0, 0, cyc, nb);
      check("chain_sum",  32'(sum0), 0);
      check("chain_cout", 32'(cout0), 1);
      check("chain_ovf",  32'(ovf0), 0);

      launch(0, 6'd31, 6'd1, 1'b0);
      run_op(0, 0, 0, cyc, nb);
      check("sovf_sum",  32'(sum0), 32);
      check("sovf_cout", 32'(cout0), 0);
      check("sovf_ovf",  32'(ovf0), 1);

      // Back-to-back: start held through DONE.
      launch(0, 6'd20, 6'd22, 1'b0);
      @(negedge clk);
      a_v[0] = 6'd10;
      b_v[0] = 6'd5;
      run_op(0, 0, 1, cyc, nb);
      check("b2b_first_sum", 32'(sum0), 42);
      run_op(0, 0, 0, cyc, nb);
      check("b2b_gap",  32'(cyc), 7);
      check("b2b_busy", 32'(nb), 6);
      check("b2b_sum",  32'(sum0), 15);

      // Reset mid-RUN.
      launch(0, 6'd37, 6'd29, 1'b0);
      @(negedge clk);
      start_v[0] = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("mrst_busy", 32'(busy0), 0);
      check("mrst_done", 32'(done0), 0);
      check("mrst_sum",  32'(sum0), 0);
      check("mrst_cout", 32'(cout0), 0);
      check("mrst_ovf",  32'(ovf0), 0);
      rst = 0;
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         nd += int'(done0);
      end
      check("mrst_no_done", 32'(nd), 0);
      launch(0, 6'd10, 6'd5, 1'b0);
      run_op(0, 0, 0, cyc, nb);
      check("mrst_after_lat", 32'(cyc), 7);
      check("mrst_after_sum", 32'(sum0), 15);

      // WIDTH=1 instance.
      launch(1, 6'd1, 6'd1, 1'b1);
      run_op(1, 0, 0, cyc, nb);
      check("w1_lat",  32'(cyc), 2);
      check("w1_busy", 32'(nb), 1);
      check("w1_sum",  32'(sum1), 1);
      check("w1_cout", 32'(cout1), 1);
      check("w1_ovf",  32'(ovf1), 0);

      // Random traffic on both instances, with rare resets.
      repeat (4000) begin
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         for (int k = 0; k < 2; k++) begin
            start_v[k] = ($urandom_range(0, 2) == 0);
            a_v[k]     = 6'($urandom);
            b_v[k]     = 6'($urandom);
            cin_v[k]   = 1'($urandom);
         end
      end
      @(negedge clk);
      rst = 0;
      start_v[0] = 0;
      start_v[1] = 0;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
